// File: rtl/ristretto_clint.sv
// ristretto_clint: MSIP, prescaled 64-bit mtime/mtimecmp timer and a synchronized level/edge external
// interrupt gateway, exposed as a word-addressed register slave feeding the trap control unit.
module ristretto_clint #(
    parameter int DataWidth      = 32,
    parameter int AddrWidth      = 32,
    parameter int PrescalerWidth = 8,
    parameter int ExtSyncStages  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clint_req_i,
    input  logic                 clint_we_i,
    input  logic [AddrWidth-1:0] clint_addr_i,
    input  logic [DataWidth-1:0] clint_wdata_i,
    output logic                 clint_gnt_o,
    output logic                 clint_rvalid_o,
    output logic [DataWidth-1:0] clint_rdata_o,
    output logic                 clint_err_o,
    input  logic                 ext_irq_i,
    input  logic [1:0]           clint_trap_detected_i,
    input  logic [4:0]           clint_mcause_i,
    output logic                 clint_sw_intr_o,
    output logic                 clint_tim_intr_o,
    output logic                 clint_ext_intr_o
);
    logic [2:0]                off;
    logic                      acc_err, wr;
    logic                      wr_msip, wr_cfg, wr_psc, wr_mlo, wr_mhi, wr_clo, wr_chi;
    logic                      msip_q, msip_d, mode_q, mode_d, pend_q, pend_d;
    logic [PrescalerWidth-1:0] psc_q, psc_d, cnt_q, cnt_d;
    logic [63:0]               mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic                      tim_q;
    logic [ExtSyncStages-1:0]  sync_q;
    logic                      sync, sync_dly_q, claim, pend_set, pend_clr, psc_hit;
    logic                      rvalid_q, err_q;
    logic [DataWidth-1:0]      rd, rdata_q, rdata_d;
    logic                      unused_addr;

    assign off         = clint_addr_i[4:2];
    assign acc_err     = (clint_addr_i[1:0] != 2'b00) || (off == 3'd3);
    assign wr          = clint_req_i && clint_we_i && !acc_err;
    assign wr_msip     = wr && (off == 3'd0);
    assign wr_cfg      = wr && (off == 3'd1);
    assign wr_psc      = wr && (off == 3'd2);
    assign wr_mlo      = wr && (off == 3'd4);
    assign wr_mhi      = wr && (off == 3'd5);
    assign wr_clo      = wr && (off == 3'd6);
    assign wr_chi      = wr && (off == 3'd7);
    assign unused_addr = ^clint_addr_i[AddrWidth-1:5];

    assign sync     = sync_q[ExtSyncStages-1];
    assign claim    = (clint_trap_detected_i == 2'b01) && (clint_mcause_i == 5'd11);
    assign pend_set = mode_q && sync && !sync_dly_q;
    assign pend_clr = claim || (wr_cfg && clint_wdata_i[1]);
    assign psc_hit  = (cnt_q == psc_q);

    always_comb begin
        msip_d     = wr_msip ? clint_wdata_i[0] : msip_q;
        mode_d     = wr_cfg ? clint_wdata_i[0] : mode_q;
        // level mode forces the latch low, so leaving edge mode also drops it
        pend_d     = !mode_d ? 1'b0 : pend_set ? 1'b1 : pend_clr ? 1'b0 : pend_q;
        psc_d      = wr_psc ? clint_wdata_i[PrescalerWidth-1:0] : psc_q;
        cnt_d      = (wr_mlo || wr_mhi || psc_hit) ? '0 : cnt_q + PrescalerWidth'(1);
        mtime_d    = wr_mlo ? {mtime_q[63:32], clint_wdata_i} :
                     wr_mhi ? {clint_wdata_i, mtime_q[31:0]} :
                     psc_hit ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = wr_clo ? {mtimecmp_q[63:32], clint_wdata_i} :
                     wr_chi ? {clint_wdata_i, mtimecmp_q[31:0]} : mtimecmp_q;
        rd = '0;
        case (off)
            3'd0:    rd = DataWidth'(msip_q);
            3'd1:    rd = DataWidth'({pend_q, mode_q});
            3'd2:    rd = DataWidth'(psc_q);
            3'd4:    rd = mtime_q[31:0];
            3'd5:    rd = mtime_q[63:32];
            3'd6:    rd = mtimecmp_q[31:0];
            3'd7:    rd = mtimecmp_q[63:32];
            default: rd = '0;
        endcase
        rdata_d = (clint_req_i && !clint_we_i && !acc_err) ? rd : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            msip_q     <= 1'b0;
            mode_q     <= 1'b0;
            pend_q     <= 1'b0;
            psc_q      <= '0;
            cnt_q      <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            tim_q      <= 1'b0;
            sync_q     <= '0;
            sync_dly_q <= 1'b0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            msip_q     <= msip_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            psc_q      <= psc_d;
            cnt_q      <= cnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            tim_q      <= (mtime_q >= mtimecmp_q);
            sync_q     <= {sync_q[ExtSyncStages-2:0], ext_irq_i};
            sync_dly_q <= sync;
            rvalid_q   <= clint_req_i;
            err_q      <= clint_req_i && acc_err;
            rdata_q    <= rdata_d;
        end
    end

    assign clint_gnt_o      = clint_req_i;
    assign clint_rvalid_o   = rvalid_q;
    assign clint_rdata_o    = rdata_q;
    assign clint_err_o      = err_q;
    assign clint_sw_intr_o  = msip_q;
    assign clint_tim_intr_o = tim_q;
    assign clint_ext_intr_o = mode_q ? pend_q : sync;
endmodule

// File: tb/tb_ristretto_clint.sv
// tb_ristretto_clint: directed and randomized checks of ristretto_clint against a cycle-count based model.
module tb_ristretto_clint;
    localparam int S = 2;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req = 1'b0, we = 1'b0, ext_irq = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [1:0]  trap = '0;
    logic [4:0]  mcause = '0;
    logic        gnt, rvalid, err, sw, tim, ext;
    logic [31:0] rdata;

    ristretto_clint #(.ExtSyncStages(S)) dut (
        .clk_i(clk), .rst_i(rst),
        .clint_req_i(req), .clint_we_i(we), .clint_addr_i(addr), .clint_wdata_i(wdata),
        .clint_gnt_o(gnt), .clint_rvalid_o(rvalid), .clint_rdata_o(rdata), .clint_err_o(err),
        .ext_irq_i(ext_irq), .clint_trap_detected_i(trap), .clint_mcause_i(mcause),
        .clint_sw_intr_o(sw), .clint_tim_intr_o(tim), .clint_ext_intr_o(ext)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // pin value sampled at each of the last 8 edges, [0] = most recent
    logic [7:0] pin_hist;
    always @(posedge clk or posedge rst) pin_hist <= rst ? 8'h0 : {pin_hist[6:0], ext_irq};

    int total = 0, bad = 0;

    bit          m_msip, m_mode, m_pend, mt_ok;
    logic [7:0]  m_psc;
    logic [63:0] m_base, m_cmp;
    longint      m_load, m_cmp_edge, last_k;

    // mtime after edge e: loaded value plus one tick per (PRESCALE+1) edges since the load
    function automatic logic [63:0] mtime_at(longint e);
        return m_base + 64'((e - m_load) / (longint'(m_psc) + 1));
    endfunction

    function automatic logic [31:0] model_rd(logic [2:0] o, longint e);
        logic [63:0] mt;
        mt = mtime_at(e);
        case (o)
            3'd0:    return {31'b0, m_msip};
            3'd1:    return {30'b0, m_pend, m_mode};
            3'd2:    return {24'b0, m_psc};
            3'd4:    return mt[31:0];
            3'd5:    return mt[63:32];
            3'd6:    return m_cmp[31:0];
            3'd7:    return m_cmp[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input bit rq, input bit wr, input logic [2:0] o, input logic [31:0] wd);
        bit claim, set, nmode;
        logic [63:0] mt;
        longint e;
        claim = (trap == 2'b01) && (mcause == 5'd11);
        @(posedge clk);
        #1;
        e = cyc;
        set = m_mode && pin_hist[S] && !pin_hist[S+1];
        nmode = (wr && o == 3'd1) ? wd[0] : m_mode;
        m_pend = !nmode ? 1'b0 : set ? 1'b1 : (claim || (wr && o == 3'd1 && wd[1])) ? 1'b0 : m_pend;
        m_mode = nmode;
        chk("rvalid", rvalid, rq);
        chk("sw", sw, m_msip);
        chk("ext", ext, m_mode ? m_pend : pin_hist[S-1]);
        if (mt_ok && e - 1 >= m_load && e - 1 >= m_cmp_edge) begin
            mt = mtime_at(e - 1);
            chk("tim", tim, mt >= m_cmp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 3'd0, 32'h0);
    endtask

    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d);
        logic [2:0]  o;
        bit          er;
        logic [31:0] expv;
        logic [63:0] mt;
        longint      k;
        o = a[4:2];
        er = (a[1:0] != 2'b00) || (o == 3'd3);
        expv = (w || er) ? 32'h0 : model_rd(o, cyc);
        req = 1'b1; we = w; addr = a; wdata = d;
        #1;
        chk("gnt", gnt, 1'b1);
        k = cyc + 1;
        last_k = k;
        if (w && !er) begin
            case (o)
                3'd0: m_msip = d[0];
                3'd2: begin mt = mtime_at(k); m_base = mt; m_load = k; m_psc = d[7:0]; mt_ok = 1'b0; end
                3'd4: begin mt = mtime_at(k - 1); m_base = {mt[63:32], d}; m_load = k; mt_ok = 1'b1; end
                3'd5: begin mt = mtime_at(k - 1); m_base = {d, mt[31:0]}; m_load = k; end
                3'd6: begin m_cmp[31:0] = d; m_cmp_edge = k; end
                3'd7: begin m_cmp[63:32] = d; m_cmp_edge = k; end
                default: ;
            endcase
        end
        tick(1'b1, w && !er, o, d);
        req = 1'b0; we = 1'b0;
        chk("err", err, er);
        chk("rdata", rdata, expv);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0; we = 1'b0; ext_irq = 1'b0; trap = '0; mcause = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_sw", sw, 1'b0);
        chk("rst_tim", tim, 1'b0);
        chk("rst_ext", ext, 1'b0);
        rst = 1'b0;
        m_msip = 0; m_mode = 0; m_pend = 0; m_psc = '0; m_base = '0; m_load = cyc;
        m_cmp = '1; m_cmp_edge = cyc; mt_ok = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        longint k, first;
        logic [31:0] lo, hi;
        int delta;
        do_reset();
        // reset values of the compare register and a running mtime
        xfer(1'b0, 32'h18, 0); chk("cmp_lo_rst", rdata, 32'hFFFF_FFFF);
        xfer(1'b0, 32'h1C, 0); chk("cmp_hi_rst", rdata, 32'hFFFF_FFFF);
        xfer(1'b0, 32'h10, 0);
        idle(100);
        chk("tim_idle", tim, 1'b0);

        // prescaled count up to a compare value of 10
        xfer(1'b1, 32'h08, 3);
        xfer(1'b1, 32'h1C, 0);
        xfer(1'b1, 32'h18, 10);
        xfer(1'b1, 32'h10, 0);
        k = last_k;
        first = -1;
        for (int i = 0; i < 100 && first < 0; i++) begin
            if (i % 7 == 3) xfer(1'b0, 32'h10, 0);
            else idle(1);
            if (tim) first = cyc;
        end
        chk("tim_rise_edge", 64'(first), 64'(k + 41));

        // wrap of an all-ones mtime against an all-ones compare
        xfer(1'b1, 32'h1C, 32'hFFFF_FFFF);
        xfer(1'b1, 32'h18, 32'hFFFF_FFFF);
        xfer(1'b1, 32'h08, 0);
        xfer(1'b1, 32'h14, 32'hFFFF_FFFF);
        xfer(1'b1, 32'h10, 32'hFFFF_FFFF);
        idle(1); chk("tim_allones", tim, 1'b1);
        idle(1); chk("tim_wrapped", tim, 1'b0);
        xfer(1'b0, 32'h14, 0); chk("mtime_hi_wrap", rdata, 32'h0);

        // software interrupt
        chk("sw_before", sw, 1'b0);
        xfer(1'b1, 32'h00, 1); chk("sw_set", sw, 1'b1);
        idle(4);
        xfer(1'b1, 32'h00, 0); chk("sw_clr", sw, 1'b0);

        // edge gateway: latch, claim, claim colliding with a new edge
        xfer(1'b1, 32'h04, 1);
        idle(3);
        ext_irq = 1'b1;
        idle(1); chk("edge_n", ext, 1'b0);
        idle(1); chk("edge_n1", ext, 1'b0);
        idle(1); chk("edge_n2", ext, 1'b1);
        idle(2);
        ext_irq = 1'b0;
        idle(4); chk("edge_held", ext, 1'b1);
        trap = 2'b01; mcause = 5'd11;
        idle(1); chk("claim_clr", ext, 1'b0);
        trap = 2'b00; mcause = 5'd0;
        idle(2); chk("claim_stay", ext, 1'b0);
        ext_irq = 1'b1; idle(4); ext_irq = 1'b0; idle(3);
        ext_irq = 1'b1;
        idle(2);
        trap = 2'b01; mcause = 5'd11;
        idle(1); chk("set_wins", ext, 1'b1);
        trap = 2'b00; mcause = 5'd0;
        idle(1); chk("set_wins_hold", ext, 1'b1);
        trap = 2'b01; mcause = 5'd11;
        idle(1); chk("claim2_clr", ext, 1'b0);
        trap = 2'b00; mcause = 5'd0;
        ext_irq = 1'b0;
        idle(3);

        // W1C and mode switch clearing the latch
        ext_irq = 1'b1; idle(4); ext_irq = 1'b0; idle(3);
        xfer(1'b0, 32'h04, 0); chk("cfg_pend", rdata, 32'h3);
        xfer(1'b1, 32'h04, 3); chk("w1c_ext", ext, 1'b0);
        xfer(1'b0, 32'h04, 0); chk("cfg_w1c", rdata, 32'h1);
        ext_irq = 1'b1; idle(4); ext_irq = 1'b0; idle(3);
        xfer(1'b1, 32'h04, 0);
        xfer(1'b1, 32'h04, 1);
        xfer(1'b0, 32'h04, 0); chk("cfg_modesw", rdata, 32'h1);

        // random pin and trap activity in level then edge mode
        xfer(1'b1, 32'h04, 0);
        for (int i = 0; i < 40; i++) begin
            ext_irq = 1'($urandom);
            trap = 2'($urandom);
            mcause = $urandom_range(0, 1) ? 5'd11 : 5'd7;
            idle(1);
        end
        xfer(1'b1, 32'h04, 1);
        for (int i = 0; i < 60; i++) begin
            ext_irq = 1'($urandom);
            trap = 2'($urandom);
            mcause = $urandom_range(0, 1) ? 5'd11 : 5'd7;
            idle(1);
        end
        ext_irq = 1'b0; trap = '0; mcause = '0;
        idle(4);

        // access errors leave state untouched
        xfer(1'b0, 32'h0C, 0); chk("err_unmapped", err, 1'b1);
        xfer(1'b1, 32'h0C, 32'h1234);
        xfer(1'b1, 32'h02, 1); chk("err_misalign", err, 1'b1);
        xfer(1'b0, 32'h00, 0); chk("msip_untouched", rdata, 32'h0);

        // random timer programming with interleaved reads
        for (int it = 0; it < 6; it++) begin
            hi = $urandom;
            lo = $urandom_range(0, 1000);
            delta = $urandom_range(0, 60);
            xfer(1'b1, 32'h1C, hi);
            xfer(1'b1, 32'h18, lo + 32'(delta));
            xfer(1'b1, 32'h08, $urandom_range(0, 3));
            xfer(1'b1, 32'h14, hi);
            xfer(1'b1, 32'h10, lo);
            for (int c = 0; c < 80; c++) begin
                if ($urandom_range(0, 2) == 0) xfer(1'b0, {27'b0, 3'($urandom), 2'b00}, 0);
                else idle(1);
            end
        end

        // reset while a read response is in flight
        xfer(1'b1, 32'h00, 1);
        xfer(1'b1, 32'h1C, 0);
        xfer(1'b1, 32'h18, 0);
        idle(2); chk("tim_pre_rst", tim, 1'b1);
        req = 1'b1; we = 1'b0; addr = 32'h18;
        @(posedge clk);
        #1;
        chk("rvalid_pre_rst", rvalid, 1'b1);
        rst = 1'b1; req = 1'b0;
        #1;
        chk("mid_rvalid", rvalid, 1'b0);
        chk("mid_rdata", rdata, 32'h0);
        chk("mid_sw", sw, 1'b0);
        chk("mid_tim", tim, 1'b0);
        chk("mid_ext", ext, 1'b0);
        do_reset();
        xfer(1'b0, 32'h1C, 0); chk("cmp_hi_rst2", rdata, 32'hFFFF_FFFF);
        xfer(1'b0, 32'h00, 0); chk("msip_rst2", rdata, 32'h0);
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
